// File: rtl/sram_wr_pkg.sv
// Shared types, default timing constants and the lane-select helper for the
// SRAM write-sequencing stage.
package sram_wr_pkg;

    // Default geometry and strobe timing
    localparam int DW_DEF        = 16;
    localparam int AW_DEF        = 3;
    localparam int DEPTH_DEF     = 4;
    localparam int SETUP_CYC_DEF = 1;
    localparam int PULSE_CYC_DEF = 2;

    // Widest lane address / select vector the helper supports
    localparam int MAX_AW  = 8;
    localparam int SEL_MAX = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wr_state_e;

    // Repeats the aw-bit lane address across the whole select vector; the
    // caller keeps the low DW*AW bits (one field per data bit).
    function automatic logic [SEL_MAX-1:0] replicate_lane(input logic [MAX_AW-1:0] lane,
                                                          input int aw);
        logic [SEL_MAX-1:0] r;
        r = '0;
        for (int b = 0; b < SEL_MAX; b++) begin
            r[b] = lane[b % aw];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_wr_ctrl_if.sv
// Word-write request handshake between a requester and the write controller.
interface sram_wr_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 3
) ();
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/sram_wr_fifo.sv
// Small synchronous request FIFO with first-word fall-through read data.
module sram_wr_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage write
    // NOTE: the data array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_wr_ctrl.sv
// Write sequencer feeding the 16-bit lane demux: buffers requests, presents
// lane select and data, then fires a timed one-hot write-enable strobe.
module sram_wr_ctrl
    import sram_wr_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_wr_ctrl_if.slave       req_bus,
    output logic [DW*AW-1:0]    sel,
    output logic [DW-1:0]       din,
    output logic [2**AW-1:0]    we,
    output logic                busy,
    output logic                done
);
    localparam int NL      = 2**AW;
    localparam int SELW    = DW * AW;
    localparam int FW      = AW + DW;
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    wr_state_e               state;
    wr_state_e               state_nx;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nx;
    logic                    pop;
    logic                    push;
    logic [AW-1:0]           lane;
    logic [NL-1:0]           lane_oh;
    logic [FW-1:0]           fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    assign req_bus.req_ready = ~fifo_full;
    assign push              = req_bus.req_valid & ~fifo_full;
    assign busy              = (state != IDLE) || (fifo_count != '0);
    assign lane_oh           = NL'(1) << lane;

    sram_wr_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({req_bus.req_addr, req_bus.req_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Demux select: every per-bit field carries the current lane
    always_comb begin
        sel = SELW'(replicate_lane(MAX_AW'(lane), AW));
    end

    // Next-state, timing counter and pop decision
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CW'(SETUP_CYC - 1)) begin
                    cnt_nx   = '0;
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            STROBE: begin
                if (cnt == CW'(PULSE_CYC - 1)) begin
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                cnt_nx = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = SETUP;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, lane/data capture on pop, and registered strobe/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lane  <= '0;
            din   <= '0;
            we    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (pop) begin
                {lane, din} <= fifo_rdata;
            end
            we   <= (state_nx == STROBE) ? lane_oh : '0;
            done <= (state_nx == HOLD);
        end
    end

endmodule

// File: doc/sram_wr_ctrl.md
Name: sram_wr_ctrl

Overview:
Write-sequencing stage directly upstream of the 16-bit lane demultiplexer (DEMUX_16) in the SRAM library. It accepts word-write requests over a valid/ready handshake and buffers them in a small FIFO. For each request it drives the demux's per-bit lane select and data, then issues a timed, one-hot write-enable strobe to the addressed storage lane. Setup/strobe/hold timing is guaranteed so the lane latches stable data.

Parameters:
DW, 16, data width; one lane select field per data bit
AW, 3, lane address width; 2**AW lanes (8)
DEPTH, 4, request FIFO depth; power of two, >=2
SETUP_CYC, 1, cycles sel/din are stable before the strobe; >=1
PULSE_CYC, 2, write-enable strobe width in cycles; >=1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  write request valid
req_ready  out  1  request accepted when valid&ready at clk edge
req_addr  in  AW  target lane
req_data  in  DW  write word
sel  out  DW*AW  demux select; AW-bit field per data bit, all fields = current lane
din  out  DW  demux data
we  out  2**AW  one-hot lane write enable
busy  out  1  FIFO non-empty or FSM not IDLE
done  out  1  one-cycle pulse: write completed

Behaviour:
- Reset (async on rst_n low): FIFO empty, state IDLE, counters 0; sel=0, din=0, we=0, done=0, busy=0; req_ready=1 after reset releases.
- req_ready = !fifo_full (registered count only, no bypass). Push on valid&ready. A request presented while req_ready=0 is ignored; the requester holds it.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if FIFO non-empty, pop and load {sel,din} at the same edge, then go to SETUP. Otherwise stay.
- SETUP: we=0. Stay SETUP_CYC cycles, then go to STROBE.
- STROBE: we = 1<<lane. Stay PULSE_CYC cycles, then go to HOLD.
- HOLD: one cycle. we=0, sel/din held, done=1. Next state:
  - if FIFO non-empty: pop, reload, go to SETUP (no IDLE bubble);
  - else go to IDLE.
- sel, din and the internal lane register change only on a pop. They hold their last value while IDLE.
- we is registered and glitch-free; at most one bit is ever set.
- Latency: request accepted at edge 0 → sel/din valid after edge 1 → we high after edges 1+SETUP_CYC .. SETUP_CYC+PULSE_CYC → done after edge SETUP_CYC+PULSE_CYC+1.
- Back-to-back throughput: one write per SETUP_CYC+PULSE_CYC+1 cycles.
- Simultaneous push and pop: count unchanged; data order preserved (strict FIFO).
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- busy = (state != IDLE) | (count != 0).
- Reset mid-operation: we drops immediately (async). Any in-flight and queued writes are discarded with no done pulse.

Decomposition:
- Package sram_wr_pkg: state enum (IDLE/SETUP/STROBE/HOLD), default timing constants, function to replicate a lane address into the DW*AW select vector.
- Sub-module sram_wr_fifo: synchronous FIFO with push/pop/full/empty/count, width AW+DW, async active-low reset.
- The FSM, timing counter and output registers live in sram_wr_ctrl.

Test Plan:
All scenarios use default parameters.
1. Hold rst_n low, then release → sel=0, din=0, we=0, done=0, busy=0, req_ready=1.
2. Single request, addr=5, data=16'hA5C3, accepted at edge 0 →
   - after edge 1: sel=48'hB6DB6DB6DB6D, din=16'hA5C3;
   - we=8'h20 for exactly 2 cycles (after edges 2–3);
   - done=1 after edge 4;
   - busy=0 after edge 5.
3. Six back-to-back requests, addr 0..5 →
   - req_ready falls after edge 4 (count=4);
   - strobes occur in order 8'h01,8'h02,…,8'h20, each 4 cycles apart, with no IDLE bubble;
   - exactly 6 done pulses.
4. rst_n asserted during STROBE with 2 entries queued →
   - we=0 immediately; FIFO empty, no further strobes or done pulses;
   - a following request (addr=3, data=16'h1234) completes with we=8'h08.
5. FIFO at count=3, push during the HOLD-cycle pop → count stays 3, req_ready stays 1, FIFO order preserved.
6. Lane boundaries:
   - addr=0, data=16'hFFFF → sel=0, we=8'h01;
   - addr=7, data=16'h0000 → sel=48'hFFFFFFFFFFFF, din=0, we=8'h80.
